mem_datos_filtro: RTL and testbench
===================================

# mem_datos_filtro

Byte-wide data memory that sits directly downstream of the filter processor's RAM port and returns its read data. It serves the processor's `mem_RE_RAM`/`mem_WE_RAM` accesses with fixed single-cycle read latency. A secondary host port loads and dumps images with a valid/ready handshake. A built-in clear engine zeroes the whole array.

## Interface
- `ADDR_W`, default 16: word-address width; depth = 2**`ADDR_W` bytes.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_RE_RAM` in 1: processor read strobe.
- `mem_WE_RAM` in 1: processor write strobe.
- `Data_Dir_RAM` in 32: processor byte address.
- `Data_RAM` in 8: processor write data.
- `Data_in_RAM` out 8: registered read data back to the processor.
- `host_valid` in 1: host request valid.
- `host_ready` out 1: host request accepted this cycle.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in `ADDR_W`: host address.
- `host_wdata` in 8: host write data.
- `host_rdata` out 8: host read data.
- `host_rvalid` out 1: one-cycle pulse; `host_rdata` is valid.
- `clr_start` in 1: pulse that starts a full-array clear.
- `clr_busy` out 1: clear in progress.
- `err_oob` out 1: sticky out-of-range processor access flag.

## Operation
- **Reset values:** `Data_in_RAM`=0, `host_rdata`=0, `host_rvalid`=0, `clr_busy`=0, `err_oob`=0, FSM=IDLE. Array contents are not reset.
- **FSM IDLE to CLEAR:**
  - Occurs on `clr_start`=1; the clear counter loads 0.
  - CLEAR writes 0 to address counter, then counter+1, each cycle.
  - CLEAR exits to IDLE after writing address 2**`ADDR_W`−1.
  - `clr_start` during CLEAR is ignored.
- **During CLEAR:**
  - Processor writes are dropped.
  - Processor reads return 0.
  - `host_ready`=0.
  - `clr_busy`=1.
- **Processor port (IDLE):**
  - Always serviced, never stalled.
  - Access address = `Data_Dir_RAM[ADDR_W-1:0]`.
- **Processor write:** when `mem_WE_RAM`=1, the array is written at the edge.
- **Processor read:** when `mem_RE_RAM`=1, `Data_in_RAM` takes the array byte at the next edge. Otherwise `Data_in_RAM` holds its value.
- **RE and WE both high, same cycle:** read-before-write. `Data_in_RAM` returns the old byte; the new byte is stored.
- **Host arbitration:**
  - `host_ready` = `host_valid` & IDLE & ~`mem_RE_RAM` & ~`mem_WE_RAM`.
  - The processor always has priority.
  - The host holds its request and fields stable until ready.
- **Host transfer:** when valid & ready:
  - a write stores `host_wdata`;
  - a read loads `host_rdata` and pulses `host_rvalid` on the next cycle.
- **Out-of-range (macro enabled):**
  - Condition: `Data_Dir_RAM[31:ADDR_W]` ≠ 0 on any processor strobe.
  - The write is dropped; the read returns 0.
  - `err_oob` sets and stays set until reset.

## Timing
- **Processor read latency:** 1 cycle (address at edge N, data valid after edge N+1).
- **Host read latency:** 1 cycle after the accepting edge, plus `host_rvalid`.
- **Clear duration:** exactly 2**`ADDR_W` cycles after the edge sampling `clr_start`; `clr_busy` deasserts on the following edge.
- **Reset mid-clear:** aborts the clear. FSM returns to IDLE; already-zeroed bytes stay zero and the rest are untouched.
- **Back-to-back processor reads:** one per cycle, full throughput.
- **Host starvation:** possible while the processor strobes continuously. This is acceptable by design.

## Configuration
- **`MEM_DATOS_OOB_CHECK_EN` defined:** out-of-range detection, dropping and `err_oob` are implemented as above.
- **`MEM_DATOS_OOB_CHECK_EN` undefined:**
  - Upper address bits are ignored and addresses alias modulo 2**`ADDR_W`.
  - `err_oob` is tied 0.

## Test plan
- **Reset:** `rst_n`=0 mid-run → all outputs 0 immediately, without waiting for a clock edge.
- **Processor write/read:** WE addr 0x10 data 0xA5, then RE addr 0x10 → `Data_in_RAM`=0xA5 one cycle after the RE edge.
- **Simultaneous RE/WE:** addr 0x10 holds 0xA5; RE+WE, data 0x3C → `Data_in_RAM`=0xA5. The next read returns 0x3C.
- **Host write during processor traffic:** `host_valid` write 0x22 to 0x20 while the processor strobes for 3 cycles → `host_ready` stays 0 for 3 cycles, then 1. A host read of 0x20 then gives `host_rvalid` with `host_rdata`=0x22.
- **Clear (`ADDR_W`=4):** pulse `clr_start` → `clr_busy`=1 for 16 cycles. Processor write attempts during the clear are dropped. All 16 addresses then read 0.
- **Out-of-range (macro on):** WE to 0x0001_0005, data 0xFF → addr 5 unchanged, `err_oob`=1 and sticky. With the macro off, addr 5 reads 0xFF and `err_oob`=0.

Source files
------------

// File: rtl/mem_datos_filtro.sv
// ============================================================================
// Module   : mem_datos_filtro
// Purpose  : Byte-wide data memory for the filter processor's RAM port, with
//            a host load/dump port and a full-array clear engine.
//            Optional out-of-range check: define MEM_DATOS_OOB_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_datos_filtro #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_RE_RAM,
    input  logic              mem_WE_RAM,
    input  logic [31:0]       Data_Dir_RAM,
    input  logic [7:0]        Data_RAM,
    output logic [7:0]        Data_in_RAM,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              err_oob
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] C_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [7:0]        mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic              err_oob_q, err_oob_d;

    logic              w_idle;
    logic              w_oob;
    logic [ADDR_W-1:0] w_proc_addr;
    logic              w_host_acc;
    logic              w_proc_wr;
    logic              w_host_wr;

    assign w_idle      = (state_q == ST_IDLE);
    assign w_proc_addr = Data_Dir_RAM[ADDR_W-1:0];

`ifdef MEM_DATOS_OOB_CHECK_EN
    assign w_oob = |Data_Dir_RAM[31:ADDR_W];
`else
    // Upper address bits are deliberately ignored: addresses alias modulo depth.
    logic addr_hi_unused;
    assign addr_hi_unused = ^Data_Dir_RAM[31:ADDR_W];
    assign w_oob          = 1'b0;
`endif

    // Processor owns the array whenever it strobes; the host only gets idle slots.
    assign w_host_acc = host_valid & w_idle & ~mem_RE_RAM & ~mem_WE_RAM;
    assign w_proc_wr  = w_idle & mem_WE_RAM & ~w_oob;
    assign w_host_wr  = w_host_acc & host_we;

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        rd_data_d     = rd_data_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = w_host_acc & ~host_we;
        err_oob_d     = err_oob_q | (w_oob & (mem_RE_RAM | mem_WE_RAM));

        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + C_ONE;
                if (clr_cnt_q == C_LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Array read sees the pre-edge contents, giving read-before-write.
        if (mem_RE_RAM) begin
            rd_data_d = (w_idle && !w_oob) ? mem[w_proc_addr] : 8'h00;
        end

        if (w_host_acc && !host_we) begin
            host_rdata_d = mem[host_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            clr_cnt_q     <= '0;
            rd_data_q     <= 8'h00;
            host_rdata_q  <= 8'h00;
            host_rvalid_q <= 1'b0;
            err_oob_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            rd_data_q     <= rd_data_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            err_oob_q     <= err_oob_d;
        end
    end

    // Array contents are intentionally not reset; a clear is an explicit operation.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= 8'h00;
        end else if (w_proc_wr) begin
            mem[w_proc_addr] <= Data_RAM;
        end else if (w_host_wr) begin
            mem[host_addr] <= host_wdata;
        end
    end

    assign Data_in_RAM = rd_data_q;
    assign host_ready  = w_host_acc;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign clr_busy    = (state_q == ST_CLEAR);
    assign err_oob     = err_oob_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_datos_filtro.sv
// ============================================================================
// Module   : tb_mem_datos_filtro
// Purpose  : Self-checking bench for mem_datos_filtro against an array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_datos_filtro;

    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          mem_RE_RAM = 1'b0;
    logic          mem_WE_RAM = 1'b0;
    logic [31:0]   Data_Dir_RAM = '0;
    logic [7:0]    Data_RAM = '0;
    logic [7:0]    Data_in_RAM;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [7:0]    host_wdata = '0;
    logic [7:0]    host_rdata;
    logic          host_rvalid;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          err_oob;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain byte array plus the expected output registers.
    logic [7:0] mdl [DEPTH];
    logic [7:0] exp_din = 8'h00;
    logic [7:0] exp_hrd = 8'h00;
    logic       exp_hrv = 1'b0;
    logic       exp_err = 1'b0;

    mem_datos_filtro #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_RE_RAM   (mem_RE_RAM),
        .mem_WE_RAM   (mem_WE_RAM),
        .Data_Dir_RAM (Data_Dir_RAM),
        .Data_RAM     (Data_RAM),
        .Data_in_RAM  (Data_in_RAM),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .err_oob      (err_oob)
    );

    always #5 clk = ~clk;

    function automatic logic is_oob(input logic [31:0] a);
`ifdef MEM_DATOS_OOB_CHECK_EN
        return (a >= 32'(DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        exp_din = 8'h00;
        exp_hrd = 8'h00;
        exp_hrv = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic drive_idle();
        mem_RE_RAM   = 1'b0;
        mem_WE_RAM   = 1'b0;
        Data_Dir_RAM = '0;
        Data_RAM     = '0;
        host_valid   = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_wdata   = '0;
        clr_start    = 1'b0;
    endtask

    // One idle-state clock: drive, check ready, clock, update model, check outputs.
    task automatic cycle(input logic re, input logic we, input logic [31:0] dir,
                         input logic [7:0] dat, input logic hv, input logic hwe,
                         input logic [AW-1:0] ha, input logic [7:0] hwd,
                         output logic acc);
        logic       bad;
        logic [7:0] a;
        mem_RE_RAM   = re;
        mem_WE_RAM   = we;
        Data_Dir_RAM = dir;
        Data_RAM     = dat;
        host_valid   = hv;
        host_we      = hwe;
        host_addr    = ha;
        host_wdata   = hwd;
        #1;
        acc = hv & ~re & ~we;
        checks++;
        if (host_ready !== acc) begin
            failures++;
            $display("FAIL host_ready got=%b exp=%b t=%0t", host_ready, acc, $time);
        end
        @(posedge clk);
        #1;
        bad = is_oob(dir);
        a   = dir[7:0];
        if (re) exp_din = bad ? 8'h00 : mdl[a];
        exp_hrv = acc & ~hwe;
        if (acc && !hwe) exp_hrd = mdl[ha];
        if (we && !bad) mdl[a] = dat;
        if (acc && hwe) mdl[ha] = hwd;
        if ((re || we) && bad) exp_err = 1'b1;
        checks++;
        if (Data_in_RAM !== exp_din) begin
            failures++;
            $display("FAIL Data_in_RAM addr=%h got=%h exp=%h t=%0t", dir, Data_in_RAM, exp_din, $time);
        end
        checks++;
        if (host_rvalid !== exp_hrv || (exp_hrv && host_rdata !== exp_hrd)) begin
            failures++;
            $display("FAIL host_read got=%b/%h exp=%b/%h t=%0t", host_rvalid, host_rdata, exp_hrv, exp_hrd, $time);
        end
        checks++;
        if (err_oob !== exp_err || clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL err_busy got=%b/%b exp=%b/0 t=%0t", err_oob, clr_busy, exp_err, $time);
        end
        drive_idle();
    endtask

    task automatic proc(input logic re, input logic we, input logic [31:0] dir, input logic [7:0] dat);
        logic acc;
        cycle(re, we, dir, dat, 1'b0, 1'b0, '0, 8'h00, acc);
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({Data_in_RAM, host_rdata, host_rvalid, clr_busy, err_oob, host_ready} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h/%b/%b/%b exp=0", Data_in_RAM, host_rdata, host_rvalid, clr_busy, err_oob);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_clear();
        int   cnt;
        logic rdy_seen;
        proc(1'b0, 1'b1, 32'h3, 8'h5A);
        proc(1'b1, 1'b0, 32'h3, 8'h00);
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        cnt = (clr_busy === 1'b1) ? 1 : 0;
        rdy_seen = 1'b0;
        while (clr_busy === 1'b1 && cnt < 4 * DEPTH) begin
            mem_WE_RAM   = 1'b1;
            mem_RE_RAM   = 1'b1;
            Data_Dir_RAM = 32'($urandom_range(0, DEPTH - 1));
            Data_RAM     = 8'($urandom_range(1, 255));
            host_valid   = 1'b1;
            host_we      = 1'b1;
            host_wdata   = 8'hEE;
            clr_start    = (cnt == 100);
            #1;
            if (host_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            if (clr_busy === 1'b1) cnt++;
        end
        drive_idle();
        checks++;
        if (cnt != DEPTH) begin
            failures++;
            $display("FAIL clear_cycles got=%0d exp=%0d", cnt, DEPTH);
        end
        checks++;
        if (rdy_seen !== 1'b0) begin
            failures++;
            $display("FAIL host_ready_in_clear got=1 exp=0");
        end
        checks++;
        if (Data_in_RAM !== 8'h00) begin
            failures++;
            $display("FAIL read_in_clear got=%h exp=00", Data_in_RAM);
        end
        exp_din = 8'h00;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) proc(1'b1, 1'b0, 32'(i), 8'h00);
    endtask

    task automatic test_proc_rw();
        proc(1'b0, 1'b1, 32'h10, 8'hA5);
        proc(1'b1, 1'b0, 32'h10, 8'h00);
        checks++;
        if (Data_in_RAM !== 8'hA5) begin
            failures++;
            $display("FAIL proc_read got=%h exp=a5", Data_in_RAM);
        end
        proc(1'b0, 1'b0, 32'h10, 8'h00);
        checks++;
        if (Data_in_RAM !== 8'hA5) begin
            failures++;
            $display("FAIL proc_hold got=%h exp=a5", Data_in_RAM);
        end
    endtask

    task automatic test_simul_rw();
        proc(1'b1, 1'b1, 32'h10, 8'h3C);
        checks++;
        if (Data_in_RAM !== 8'hA5) begin
            failures++;
            $display("FAIL rbw_old got=%h exp=a5", Data_in_RAM);
        end
        proc(1'b1, 1'b0, 32'h10, 8'h00);
        checks++;
        if (Data_in_RAM !== 8'h3C) begin
            failures++;
            $display("FAIL rbw_new got=%h exp=3c", Data_in_RAM);
        end
    endtask

    task automatic test_host();
        logic acc;
        int   waits;
        waits = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 8'h77,
                  1'b1, 1'b1, 8'h20, 8'h22, acc);
            if (acc) waits = 100;
        end
        cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h22, acc);
        checks++;
        if (acc !== 1'b1 || waits != 0) begin
            failures++;
            $display("FAIL host_starve got=%0d/%b exp=0/1", waits, acc);
        end
        cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, acc);
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h22) begin
            failures++;
            $display("FAIL host_rd got=%b/%h exp=1/22", host_rvalid, host_rdata);
        end
        proc(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic test_oob();
        proc(1'b0, 1'b1, 32'h5, 8'h11);
        proc(1'b0, 1'b1, 32'h0001_0005, 8'hFF);
        proc(1'b1, 1'b0, 32'h5, 8'h00);
        proc(1'b0, 1'b0, 32'h0, 8'h00);
        checks++;
`ifdef MEM_DATOS_OOB_CHECK_EN
        if (Data_in_RAM !== 8'h11 || err_oob !== 1'b1) begin
            failures++;
            $display("FAIL oob got=%h/%b exp=11/1", Data_in_RAM, err_oob);
        end
`else
        if (Data_in_RAM !== 8'hFF || err_oob !== 1'b0) begin
            failures++;
            $display("FAIL oob_alias got=%h/%b exp=ff/0", Data_in_RAM, err_oob);
        end
`endif
    endtask

    task automatic test_random();
        logic          hv, hwe, acc, re, we;
        logic [AW-1:0] ha;
        logic [7:0]    hwd;
        logic [31:0]   dir;
        hv = 1'b0; hwe = 1'b0; ha = '0; hwd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hv && $urandom_range(0, 1) == 1) begin
                hv  = 1'b1;
                hwe = 1'($urandom_range(0, 1));
                ha  = AW'($urandom_range(0, DEPTH - 1));
                hwd = 8'($urandom);
            end
            re  = ($urandom_range(0, 9) < 4);
            we  = ($urandom_range(0, 9) < 4);
            dir = 32'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 15) == 0) dir[20] = 1'b1;
            cycle(re, we, dir, 8'($urandom), hv, hwe, ha, hwd, acc);
            if (acc) hv = 1'b0;
        end
    endtask

    task automatic test_reset_async();
        logic acc;
        proc(1'b0, 1'b1, 32'h40, 8'h81);
        cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 8'h41, 8'h42, acc);
        proc(1'b1, 1'b0, 32'h40, 8'h00);
        cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 8'h41, 8'h00, acc);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({Data_in_RAM, host_rdata, host_rvalid, clr_busy, err_oob} !== 19'h0) begin
            failures++;
            $display("FAIL async_reset got=%h/%h/%b/%b/%b exp=0", Data_in_RAM, host_rdata, host_rvalid, clr_busy, err_oob);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_clear();
        logic acc;
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, AW'(i), 8'($urandom_range(1, 255)), acc);
        clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_clear_busy got=%b exp=0", clr_busy);
        end
        model_reset();
        for (int i = 0; i < 50; i++) mdl[i] = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) proc(1'b1, 1'b0, 32'(i), 8'h00);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_back_to_back();
        test_proc_rw();
        test_simul_rw();
        test_host();
        test_oob();
        test_random();
        test_reset_async();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
